// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// using one full-subtractor cell and a borrow flop behind a start/busy/done handshake.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] pd_q, pd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic a0, b0, d_bit, br_nx;

  always_comb begin
    a0    = a_sh_q[0];
    b0    = b_sh_q[0];
    d_bit = a0 ^ b0 ^ br_q;
    br_nx = (~a0 & b0) | (~a0 & br_q) | (b0 & br_q);

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    pd_d    = pd_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        pd_d   = {d_bit, pd_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // On the MSB step br_q is the borrow into the MSB, so overflow is its XOR with borrow-out.
          diff_d  = {d_bit, pd_q[WIDTH-1:1]};
          bout_d  = br_nx;
          ovf_d   = br_q ^ br_nx;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      pd_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      pd_q    <= pd_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: WIDTH=8 directed vectors and a WIDTH=5 random sweep,
// checked against an arithmetic timeline model plus literal expectations.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       start5 = 1'b0, bin5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       busy5, done5, bout5, ovf5;
  logic [4:0] diff5;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .a(a5), .b(b5), .bin(bin5),
    .busy(busy5), .done(done5), .diff(diff5), .bout(bout5), .ovf(ovf5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: modulo difference, unsigned borrow, signed overflow.
  function automatic void ref_sub(input int w, input int a, input int b, input int bi,
                                  output int d, output int bo, output int ov);
    int m, h, sa, sb, r;
    m  = 1 << w;
    h  = m / 2;
    d  = (a - b - bi + m) % m;
    bo = (a < b + bi) ? 1 : 0;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r  = sa - sb - bi;
    ov = (r < -h || r > h - 1) ? 1 : 0;
  endfunction

  // Timeline model: k = edges since the accepting edge (-1 when idle).
  int W[2]   = '{8, 5};
  int k[2]   = '{-1, -1};
  int ma[2]  = '{0, 0};
  int mb[2]  = '{0, 0};
  int mbi[2] = '{0, 0};
  int ed[2]  = '{0, 0};
  int eb[2]  = '{0, 0};
  int eo[2]  = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    logic s;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        k[i] = -1; ed[i] = 0; eb[i] = 0; eo[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        s = (i == 0) ? start8 : start5;
        if (k[i] < 0) begin
          if (s) begin
            k[i]   = 0;
            ma[i]  = (i == 0) ? int'(a8) : int'(a5);
            mb[i]  = (i == 0) ? int'(b8) : int'(b5);
            mbi[i] = (i == 0) ? int'(bin8) : int'(bin5);
          end
        end else begin
          k[i]++;
          if (k[i] == W[i]) ref_sub(W[i], ma[i], mb[i], mbi[i], ed[i], eb[i], eo[i]);
          else if (k[i] > W[i]) k[i] = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy8", 32'(busy8), 32'(k[0] >= 0 && k[0] < W[0]));
    chk("done8", 32'(done8), 32'(k[0] == W[0]));
    chk("diff8", 32'(diff8), ed[0]);
    chk("bout8", 32'(bout8), eb[0]);
    chk("ovf8",  32'(ovf8),  eo[0]);
    chk("busy5", 32'(busy5), 32'(k[1] >= 0 && k[1] < W[1]));
    chk("done5", 32'(done5), 32'(k[1] == W[1]));
    chk("diff5", 32'(diff5), ed[1]);
    chk("bout5", 32'(bout5), eb[1]);
    chk("ovf5",  32'(ovf5),  eo[1]);
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] xd, input logic xb, input logic xo, input string nm);
    int n, nb;
    @(posedge clk); #2;
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #2;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    n  = 1;
    nb = busy8 ? 1 : 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy8) nb++;
    end
    chk({nm, "_done_edge"}, n, 9);
    chk({nm, "_busy_cycles"}, nb, 8);
    chk({nm, "_diff"}, 32'(diff8), 32'(xd));
    chk({nm, "_bout"}, 32'(bout8), 32'(xb));
    chk({nm, "_ovf"},  32'(ovf8),  32'(xo));
  endtask

  task automatic wait_done8(input string nm);
    int n;
    n = 0;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done8), 1);
  endtask

  initial begin
    int t1, t2, nd, d, bo, ov;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bout", 32'(bout8), 0);
    chk("rst_ovf",  32'(ovf8),  0);
    @(posedge clk); #2 rst_n = 1'b1;

    op8(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0, "sub100_37");
    op8(8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, 1'b0, "sub5_9");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_diff", 32'(diff8), 32'hFC);
    chk("hold_bout", 32'(bout8), 1);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub80_01");
    op8(8'd10, 8'd3, 1'b1, 8'd6, 1'b0, 1'b0, "sub10_3_1");

    // Second start during RUN must be ignored.
    @(posedge clk); #2;
    a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #2 start8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    a8 = 8'd1; b8 = 8'd2; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #2 start8 = 1'b0;
    wait_done8("ignore");
    chk("ignore_diff", 32'(diff8), 145);
    chk("ignore_bout", 32'(bout8), 0);

    // Start held high: back-to-back operations.
    @(posedge clk); #2;
    a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
    t1 = -1; t2 = -1;
    for (int n = 0; n < 40 && t2 < 0; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    chk("b2b_spacing", t2 - t1, 10);
    chk("b2b_diff", 32'(diff8), 30);
    #1 start8 = 1'b0;
    repeat (12) @(posedge clk);

    // Asynchronous reset mid-RUN.
    #2;
    a8 = 8'd77; b8 = 8'd11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #2 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 0);
    chk("arst_done", 32'(done8), 0);
    chk("arst_diff", 32'(diff8), 0);
    chk("arst_bout", 32'(bout8), 0);
    chk("arst_ovf",  32'(ovf8),  0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    chk("arst_no_done", nd, 0);
    op8(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b0, "sub0_0_1");

    // WIDTH=5 random sweep.
    for (int i = 0; i < 200; i++) begin
      int n;
      @(posedge clk); #2;
      a5 = 5'($urandom); b5 = 5'($urandom); bin5 = 1'($urandom);
      ref_sub(5, int'(a5), int'(b5), int'(bin5), d, bo, ov);
      start5 = 1'b1;
      @(posedge clk); #2;
      start5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom);
      n = 1;
      while (!done5 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("w5_done_edge", n, 6);
      chk("w5_diff", 32'(diff5), d);
      chk("w5_bout", 32'(bout5), bo);
      chk("w5_ovf",  32'(ovf5),  ov);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errs=%0d", errs);
    $fatal(1, "watchdog");
  end

endmodule
